// File: rtl/reducer_noc.sv
// Reducer NoC endpoint: buffers the 32-bit word stream of 128-bit key/count pairs, merges equal
// keys into a count table and streams the merged table back out when a flush is requested.
module reducer_noc #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned KEY_NUM    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_in_ready,
  output logic        fifo_in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned KW = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;
  localparam int unsigned IW = $clog2(KEY_NUM + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSearch, StUpdate, StDrain, StDone} state_e;

  state_e        r_state;
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic [95:0]   r_keys [KEY_NUM];
  logic [31:0]   r_cnts [KEY_NUM];
  logic [127:0]  r_pair;
  logic [1:0]    r_ld, r_word;
  logic [IW-1:0] r_idx, r_used;
  logic          r_flush_pend, r_fifo_in_ready, r_dov, r_done, r_overflow;
  logic [31:0]   r_data_out;

  logic          w_wr, w_drop, w_rd, w_hit, w_at_end, w_tbl_new, w_upd, w_last;
  logic [CW-1:0] w_cnt_nxt;
  logic [KW-1:0] w_idx;
  logic [32:0]   w_sum;
  logic [31:0]   w_sat, w_word;

  assign w_wr      = data_in_ready && (r_cnt < CW'(FIFO_DEPTH));
  assign w_drop    = data_in_ready && !w_wr;
  assign w_rd      = (r_state == StLoad);
  assign w_cnt_nxt = r_cnt + CW'(w_wr) - CW'(w_rd);

  assign w_idx     = r_idx[KW-1:0];
  assign w_hit     = (r_idx < r_used) && (r_keys[w_idx] == r_pair[127:32]);
  assign w_at_end  = (r_idx == r_used);
  assign w_tbl_new = (r_state == StSearch) && !w_hit && w_at_end && (r_used < IW'(KEY_NUM));
  assign w_upd     = (r_state == StUpdate);
  assign w_sum     = {1'b0, r_cnts[w_idx]} + {1'b0, r_pair[31:0]};
  assign w_sat     = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
  assign w_last    = (r_idx == r_used - IW'(1)) && (r_word == 2'd3);

  always_comb begin
    w_word = r_cnts[w_idx];
    case (r_word)
      2'd1:    w_word = r_keys[w_idx][31:0];
      2'd2:    w_word = r_keys[w_idx][63:32];
      2'd3:    w_word = r_keys[w_idx][95:64];
      default: w_word = r_cnts[w_idx];
    endcase
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and r_used.
  always_ff @(posedge clk) begin
    if (w_wr) r_fifo[r_wptr] <= data_in;
    if (w_tbl_new) begin
      r_keys[w_idx] <= r_pair[127:32];
      r_cnts[w_idx] <= r_pair[31:0];
    end
    if (w_upd) r_cnts[w_idx] <= w_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= StIdle;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_cnt           <= '0;
      r_fifo_in_ready <= 1'b0;
      r_pair          <= '0;
      r_ld            <= '0;
      r_word          <= '0;
      r_idx           <= '0;
      r_used          <= '0;
      r_flush_pend    <= 1'b0;
      r_data_out      <= '0;
      r_dov           <= 1'b0;
      r_done          <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      r_cnt <= w_cnt_nxt;
      // One slot held back covers the upstream's registered-ready delay.
      r_fifo_in_ready <= (w_cnt_nxt <= CW'(FIFO_DEPTH - 2));
      if (flush) r_flush_pend <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      r_dov      <= 1'b0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (r_flush_pend && (r_cnt == '0)) begin
            r_state <= StDrain;
            r_idx   <= '0;
            r_word  <= '0;
          end else if (r_cnt >= CW'(4)) begin
            r_state <= StLoad;
            r_ld    <= '0;
          end
        end
        StLoad: begin
          r_pair[{r_ld, 5'd0} +: 32] <= r_fifo[r_rptr];
          r_ld <= r_ld + 2'd1;
          if (r_ld == 2'd3) begin
            r_state <= StSearch;
            r_idx   <= '0;
          end
        end
        StSearch: begin
          if (w_hit) begin
            r_state <= StUpdate;
          end else if (w_at_end) begin
            if (r_used < IW'(KEY_NUM)) r_used <= r_used + IW'(1);
            else r_overflow <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        StUpdate: r_state <= StIdle;
        StDrain: begin
          if (r_used == '0) begin
            r_state <= StDone;
          end else if (out_ready) begin
            r_data_out <= w_word;
            r_dov      <= 1'b1;
            r_word     <= r_word + 2'd1;
            if (w_last) r_state <= StDone;
            else if (r_word == 2'd3) r_idx <= r_idx + IW'(1);
          end
        end
        StDone: begin
          r_done       <= 1'b1;
          r_used       <= '0;
          r_flush_pend <= 1'b0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign fifo_in_ready  = r_fifo_in_ready;
  assign data_out       = r_data_out;
  assign data_out_ready = r_dov;
  assign busy           = (r_state != StIdle);
  assign done           = r_done;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_reducer_noc.sv
// Self-checking bench for reducer_noc: directed vector table, flow-control and reset corner
// cases, and randomized pair streams compared against a queue-based reduction model.
module tb_reducer_noc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_in_ready = 1'b0;
  logic        fifo_in_ready;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] data_out;
  logic        data_out_ready, busy, done, overflow;

  reducer_noc #(.FIFO_DEPTH(8), .KEY_NUM(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_ready(data_in_ready),
    .fifo_in_ready(fifo_in_ready), .flush(flush), .out_ready(out_ready),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: ordered list of distinct keys with saturating counts.
  logic [95:0] m_keys[$];
  logic [31:0] m_cnts[$];
  logic        m_ovf;

  function automatic void model_add(logic [95:0] k, logic [31:0] c);
    longint unsigned s;
    foreach (m_keys[i]) begin
      if (m_keys[i] == k) begin
        s = longint'(m_cnts[i]) + longint'(c);
        m_cnts[i] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
        return;
      end
    end
    if (m_keys.size() < 16) begin
      m_keys.push_back(k);
      m_cnts.push_back(c);
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  // Output monitor, sampled on the falling edge.
  logic [31:0] out_q[$];
  int          done_cnt = 0;
  logic        or_edge = 1'b0;
  int          or_mode = 0;

  always @(posedge clk) or_edge = out_ready;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (data_out_ready) begin
        out_q.push_back(data_out);
        chk("emit_needs_out_ready", {31'b0, or_edge}, 32'd1);
      end else begin
        chk("data_out_zero_idle", data_out, 32'd0);
      end
      if (done) done_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_in_ready = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_fifo_in_ready", {31'b0, fifo_in_ready}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_data_out_ready", {31'b0, data_out_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("ready_low_at_release", {31'b0, fifo_in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_rises_after_release", {31'b0, fifo_in_ready}, 32'd1);
    @(negedge clk);
    m_keys.delete();
    m_cnts.delete();
    m_ovf = 1'b0;
  endtask

  task automatic send_word(logic [31:0] w);
    int n = 0;
    while (!fifo_in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("send_word_ready");
    data_in = w;
    data_in_ready = 1'b1;
    @(negedge clk);
    data_in_ready = 1'b0;
  endtask

  task automatic send_pair(logic [95:0] k, logic [31:0] c);
    send_word(c);
    send_word(k[31:0]);
    send_word(k[63:32]);
    send_word(k[95:64]);
    model_add(k, c);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(string name, int d0);
    int n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) fail_now(name);
  endtask

  task automatic run_flush(string name);
    int d0;
    out_q.delete();
    d0 = done_cnt;
    pulse_flush();
    wait_done({name, "_done"}, d0);
    repeat (4) @(negedge clk);
    chk({name, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
    chk({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic compare_out(string name);
    logic [31:0] exp[$];
    foreach (m_keys[i]) begin
      exp.push_back(m_cnts[i]);
      exp.push_back(m_keys[i][31:0]);
      exp.push_back(m_keys[i][63:32]);
      exp.push_back(m_keys[i][95:64]);
    end
    chk({name, "_len"}, 32'(out_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_q.size(); i++)
      chk($sformatf("%s_w%0d", name, i), out_q[i], exp[i]);
    chk({name, "_overflow"}, {31'b0, overflow}, {31'b0, m_ovf});
    m_keys.delete();
    m_cnts.delete();
    out_q.delete();
  endtask

  typedef struct {
    logic [95:0] key;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    logic [95:0] k1, kb, kc, pool[20];
    logic [31:0] words[8];
    int          d0, n;

    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [95:0] k1, kb, kc, pool[20];
    logic [31:0] words[8];
    int          d0, n;

    vecs[0] = '{96'hA1, 32'hFFFF_FFF0, 32'h0000_0020, 32'hFFFF_FFFF};
    vecs[1] = '{96'hB2, 32'd1, 32'd3, 32'd4};
    vecs[2] = '{96'hC3, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    vecs[3] = '{96'hD4, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[4] = '{96'hE5_0000_0000_0000_0000_0001, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    k1 = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
    kb = 96'h1111_2222_3333_4444_5555_6666;
    kc = 96'h7777_8888_9999_AAAA_BBBB_CCCC;

    do_reset();

    // Same key four times merges into count 4.
    for (int i = 0; i < 4; i++) send_pair(k1, 32'd1);
    run_flush("k1x4");
    chk("k1x4_count", (out_q.size() > 0) ? out_q[0] : 32'hDEAD_BEEF, 32'd4);
    compare_out("k1x4");

    // Three distinct keys keep insertion order.
    for (int i = 0; i < 3; i++) send_pair(96'h100 + 96'(i), 32'd2);
    run_flush("three_keys");
    compare_out("three_keys");

    // Table of merge/saturation vectors.
    for (int i = 0; i < 5; i++) begin
      send_pair(vecs[i].key, vecs[i].c1);
      send_pair(vecs[i].key, vecs[i].c2);
      run_flush($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_count", i), (out_q.size() > 0) ? out_q[0] : 32'hDEAD_BEEF,
          vecs[i].exp);
      compare_out($sformatf("vec%0d", i));
    end

    // Empty table flush still pulses done once.
    run_flush("empty");
    compare_out("empty");

    // Stall DRAIN with out_ready low, then overrun fifo_in_ready by one cycle.
    send_pair(k1, 32'd9);
    out_q.delete();
    or_mode = 2;
    d0 = done_cnt;
    pulse_flush();
    repeat (30) @(negedge clk);
    chk("stall_no_words", 32'(out_q.size()), 32'd0);
    chk("stall_busy", {31'b0, busy}, 32'd1);
    words = '{32'd5, kb[31:0], kb[63:32], kb[95:64], 32'd7, kc[31:0], kc[63:32], kc[95:64]};
    for (int i = 0; i < 8; i++) begin
      data_in = words[i];
      data_in_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("ready_after_word%0d", i + 1), {31'b0, fifo_in_ready},
          {31'b0, (i + 1) <= 6});
      @(negedge clk);
    end
    data_in_ready = 1'b0;
    chk("no_drop_overflow", {31'b0, overflow}, 32'd0);
    or_mode = 0;
    wait_done("stall_done", d0);
    repeat (4) @(negedge clk);
    compare_out("stall_drain");
    model_add(kb, 32'd5);
    model_add(kc, 32'd7);
    repeat (60) @(negedge clk);
    chk("ready_returns", {31'b0, fifo_in_ready}, 32'd1);
    run_flush("after_stall");
    compare_out("after_stall");

    // 17 distinct keys overflow a 16-entry table.
    for (int i = 0; i < 17; i++) send_pair(96'h5000 + 96'(i), 32'(i + 1));
    repeat (40) @(negedge clk);
    chk("ovf_after_17", {31'b0, overflow}, 32'd1);
    run_flush("ovf_flush");
    compare_out("ovf_flush");
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Reset in the middle of a throttled drain.
    do_reset();
    for (int i = 0; i < 3; i++) send_pair(96'h9000 + 96'(i), 32'd3);
    out_q.delete();
    or_mode = 1;
    pulse_flush();
    n = 0;
    while (out_q.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("middrain_start");
    do_reset();
    or_mode = 0;
    run_flush("post_reset");
    compare_out("post_reset");

    // Randomized streams with throttled drains.
    for (int i = 0; i < 20; i++) pool[i] = {$urandom, $urandom, $urandom};
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(4, 24);
      for (int p = 0; p < n; p++) begin
        send_pair(pool[$urandom_range(0, 19)],
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_0000 + 32'($urandom_range(0, 65535))
                                              : 32'($urandom_range(0, 999)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      or_mode = 1;
      run_flush($sformatf("rand%0d", r));
      compare_out($sformatf("rand%0d", r));
      or_mode = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reducer_noc.md
# reducer_noc

Reducer-side network endpoint sitting directly downstream of the mapper's NoC port. It accepts the 32-bit word stream of 128-bit key/count pairs, buffers it in a small input FIFO with ready flow control, and merges pairs with equal keys into a local count table. On a flush request it streams the merged table out in the same 4-word pair format.

## Interface
- FIFO_DEPTH, 8: input FIFO depth in 32-bit words; power of two, minimum 8.
- KEY_NUM, 16: count-table entries (distinct keys held).

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  32  incoming pair word.
- data_in_ready  in  1  data_in valid this cycle; a word is written whenever this is 1 and the FIFO is not full.
- fifo_in_ready  out  1  registered; upstream may send while 1.
- flush  in  1  single-cycle request to emit and clear the table.
- out_ready  in  1  downstream can take a word.
- data_out  out  32  outgoing pair word; 0 when not valid.
- data_out_ready  out  1  data_out valid, one cycle per word.
- busy  out  1  engine not in IDLE.
- done  out  1  one-cycle pulse after the last flushed word.
- overflow  out  1  sticky; a new key arrived with the table full.

## Operation
- Pair format: word0 = pair[31:0] = count (unsigned); word1..word3 = pair[127:32] = key. Words travel lowest first.
- FIFO:
  - Write on data_in_ready while count < FIFO_DEPTH; a word arriving when full is dropped and sets overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_in_ready <= (next count <= FIFO_DEPTH-2). The reserved slot absorbs the one-cycle upstream registered-ready skew.
- Engine states:
  - IDLE: if flush_pend and the FIFO is empty, go to DRAIN. Otherwise, if FIFO count >= 4, go to LOAD.
  - LOAD: pop one word per cycle for 4 cycles into the pair register, then go to SEARCH with idx = 0.
  - SEARCH: one table entry per cycle, idx 0..used-1.
    - On a key match, go to UPDATE.
    - At idx == used with no match: if used < KEY_NUM, write {key, count} to entry[used], increment used and return to IDLE. Otherwise set overflow, drop the pair and return to IDLE.
  - UPDATE: entry count += pair count, saturating at 32'hFFFF_FFFF, then go to IDLE.
  - DRAIN: for entries 0..used-1, words 0..3, emit one word in each cycle following a cycle with out_ready sampled 1. After word 3 of the last entry, go to DONE. When used == 0, go straight to DONE.
  - DONE: pulse done, set used = 0, clear flush_pend, go to IDLE.
- flush_pend is set by flush in any state and only cleared in DONE. Repeated flush pulses before DONE merge into one.
- The FIFO keeps accepting words during SEARCH, UPDATE and DRAIN. Pairs received after a flush request are reduced only after DONE.
- The table is cleared only by reset and by DONE; entry contents need no reset.
- Reset mid-operation: everything returns to the reset state, including FIFO empty, used = 0 and flush_pend = 0. Partial pairs are lost.

## Timing
- Reset values: fifo_in_ready = 0, data_out = 0, data_out_ready = 0, busy = 0, done = 0, overflow = 0. fifo_in_ready rises 1 cycle after rst deasserts.
- A word written at edge t is visible to the engine at t+1.
- Pair latency, 4th word written to table updated:
  - 1 (IDLE) + 4 (LOAD) + (m+1) (SEARCH) + 1 (UPDATE) cycles on a match at idx m.
  - 1 + 4 + (used+1) cycles for a new key.
- DRAIN throughput is 1 word per cycle with out_ready held at 1. data_out_ready falls the cycle after out_ready is sampled 0.
- done asserts the cycle after the last data_out_ready. busy is 1 in every non-IDLE state.
- Simultaneous FIFO write and read in one cycle: count is unchanged and both operations take effect.

## Test plan
- Reset, then send pair key=K1, count=1 four times with out_ready=1, then pulse flush -> exactly 4 output words: 0x00000004 followed by K1[31:0], K1[63:32], K1[95:64]; done pulses once; used = 0 afterwards.
- Send 3 distinct keys, one pair each with count=2, then flush -> 12 output words in insertion order, each count 0x00000002.
- KEY_NUM=16: send 17 distinct keys -> overflow = 1 after the 17th pair; flush emits 16 entries; overflow stays 1 until reset.
- Send count 0xFFFFFFF0 then 0x20 for the same key -> flushed count is 0xFFFFFFFF.
- Drive data_in_ready continuously and ignore fifo_in_ready for one cycle after it falls -> no word is lost; fifo_in_ready drops at count 7 and returns when count <= 6.
- Toggle out_ready 1/0 during DRAIN, and assert rst mid-DRAIN -> words are emitted only after out_ready=1 cycles; after rst, all outputs are 0 and used = 0.
